// File: rtl/platform_pkg.sv
// Shared types and constants for the platform field: coordinate and colour types,
// the power-up activation pattern and the platform sprite geometry/palette.
package platform_pkg;

  typedef logic signed [10:0] coord_t;
  typedef logic [2:0][3:0]    rgb_t;

  localparam int PLAT_W    = 100;
  localparam int PLAT_H    = 30;
  localparam int SPR_ROW_W = $clog2(PLAT_H);
  localparam int SPR_COL_W = $clog2(PLAT_W);

  // Even rows fully populated, odd rows only the middle column (bit k = r*3+c).
  localparam logic [89:0] START_MASK = {15{6'b010111}};

  localparam rgb_t GRASS = 12'h2C3;
  localparam rgb_t SOIL  = 12'h852;

endpackage

// File: rtl/platform_field_if.sv
// Frame-control, beam and platform-state bundle between the game logic and the platform field.
interface platform_field_if #(
  parameter int N     = 90,
  parameter int RND_W = 15
);
  logic                   frame_tick;
  logic                   scroll_req;
  logic [2*RND_W-1:0]     rnd;
  logic [10:0]            beam_x;
  logic [9:0]             beam_y;
  platform_pkg::coord_t   plat_y [N];
  platform_pkg::coord_t   plat_x [N];
  logic [N-1:0]           plat_active;
  logic [N-1:0]           plat_moving;
  logic                   scroll_busy;
  platform_pkg::rgb_t     color;
  logic                   is_transparent;

  modport master (
    output frame_tick, scroll_req, rnd, beam_x, beam_y,
    input  plat_y, plat_x, plat_active, plat_moving, scroll_busy, color, is_transparent
  );

  modport slave (
    input  frame_tick, scroll_req, rnd, beam_x, beam_y,
    output plat_y, plat_x, plat_active, plat_moving, scroll_busy, color, is_transparent
  );
endinterface

// File: rtl/platform_sprite_rom.sv
// Platform sprite image: grass top band over soil, with 2x2 transparent corners.
module platform_sprite_rom
  import platform_pkg::*;
(
  input  logic [SPR_ROW_W-1:0] row,
  input  logic [SPR_COL_W-1:0] col,
  output rgb_t                 rgb,
  output logic                 alpha
);
  int  r, c;
  logic corner;

  always_comb begin
    r      = int'(row);
    c      = int'(col);
    corner = (r < 2 || r >= PLAT_H - 2) && (c < 2 || c >= PLAT_W - 2);
    alpha  = !corner;
    if (corner)     rgb = '1;
    else if (r < 6) rgb = GRASS;
    else            rgb = SOIL;
  end
endmodule

// File: rtl/platform_field.sv
// ROWS x COLS platform grid: scroll bursts, bank recycling with random activation,
// horizontally oscillating platforms and a registered sprite pixel for the beam.
module platform_field
  import platform_pkg::*;
#(
  parameter int ROWS        = 30,
  parameter int COLS        = 3,
  parameter int BANK        = 5,
  parameter int ROW_PITCH   = 30,
  parameter int COL_PITCH   = 114,
  parameter int X0          = 342,
  parameter int Y0          = -162,
  parameter int EARTH       = 768,
  parameter int SCROLL_STEP = 12,
  parameter int SCROLL_LEN  = 16,
  parameter int MOVING_EN   = 1,
  parameter int MOVE_STEP   = 2,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 1180,
  parameter int RND_W       = 15
) (
  input logic              clk,
  input logic              rst,
  platform_field_if.slave  bus
);
  localparam int N     = ROWS * COLS;
  localparam int NB    = ROWS / BANK;
  localparam int BW    = BANK * COLS;
  localparam int CNT_W = $clog2(SCROLL_LEN);

  // x never goes negative but may exceed +1023, so it is handled zero-extended in 12 bits.
  typedef logic signed [11:0] wide_t;

  localparam coord_t EARTH_C = coord_t'(EARTH);
  localparam coord_t STEP_C  = coord_t'(SCROLL_STEP);
  localparam coord_t WRAP_C  = coord_t'(ROWS * ROW_PITCH);
  localparam wide_t  MSTEP_W = wide_t'(MOVE_STEP);
  localparam wide_t  XLO_W   = wide_t'(X_MIN);
  localparam wide_t  XHI_W   = wide_t'(X_MAX - PLAT_W);
  localparam wide_t  PW_W    = wide_t'(PLAT_W);
  localparam wide_t  PH_W    = wide_t'(PLAT_H);

  function automatic coord_t home_x(input int k);
    return coord_t'(X0 + (k % COLS) * COL_PITCH);
  endfunction

  function automatic coord_t home_y(input int k);
    return coord_t'(Y0 + (k / COLS) * ROW_PITCH);
  endfunction

  coord_t             y_q [N], y_d [N], x_q [N], x_d [N];
  logic [N-1:0]       active_q, active_d, moving_q, moving_d, dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB-1:0]      recyc;
  logic               scrolling, rnd_zero;
  wide_t              xw, nxw, yw, bxw, byw;
  logic               any_hit;
  logic [SPR_ROW_W-1:0] win_row;
  logic [SPR_COL_W-1:0] win_col;
  rgb_t               rom_rgb, color_q, color_d;
  logic               rom_alpha, transp_q, transp_d;

  always_comb begin
    y_d       = y_q;
    x_d       = x_q;
    active_d  = active_q;
    moving_d  = moving_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    xw        = '0;
    nxw       = '0;
    scrolling = bus.frame_tick && (bus.scroll_req || cnt_q != '0);
    rnd_zero  = (bus.rnd[BW-1:0] == '0);
    if (scrolling) cnt_d = (cnt_q == CNT_W'(SCROLL_LEN - 1)) ? '0 : cnt_q + 1'b1;
    for (int b = 0; b < NB; b++) recyc[b] = bus.frame_tick && (y_q[b*BW] >= EARTH_C);
    for (int i = 0; i < N; i++) begin
      if (scrolling) y_d[i] = y_q[i] + STEP_C;
      if (recyc[i/BW]) begin
        y_d[i]      = y_d[i] - WRAP_C;
        active_d[i] = bus.rnd[i%BW] | (rnd_zero && (i % BW == BW - 1));
        moving_d[i] = (MOVING_EN != 0) && active_d[i] && bus.rnd[RND_W + i%BW];
        x_d[i]      = home_x(i);
        dir_d[i]    = 1'b0;
      end else if (bus.frame_tick && moving_q[i] && active_q[i]) begin
        xw  = $signed({1'b0, x_q[i]});
        nxw = dir_q[i] ? xw - MSTEP_W : xw + MSTEP_W;
        // Clamp at the bound and turn around in the same frame.
        if (nxw < XLO_W) begin
          nxw      = XLO_W;
          dir_d[i] = ~dir_q[i];
        end else if (nxw > XHI_W) begin
          nxw      = XHI_W;
          dir_d[i] = ~dir_q[i];
        end
        x_d[i] = nxw[10:0];
      end
    end
  end

  // Beam hit test; iterating downward lets the lowest index win.
  always_comb begin
    any_hit = 1'b0;
    win_row = '0;
    win_col = '0;
    yw      = '0;
    bxw     = $signed({1'b0, bus.beam_x});
    byw     = $signed({2'b00, bus.beam_y});
    for (int i = N - 1; i >= 0; i--) begin
      yw = wide_t'(y_q[i]);
      if (active_q[i] &&
          $signed({1'b0, x_q[i]}) <= bxw && bxw < $signed({1'b0, x_q[i]}) + PW_W &&
          yw <= byw && byw < yw + PH_W) begin
        any_hit = 1'b1;
        win_row = SPR_ROW_W'(byw - yw);
        win_col = SPR_COL_W'(bxw - $signed({1'b0, x_q[i]}));
      end
    end
    color_d  = any_hit ? rom_rgb : '1;
    transp_d = any_hit ? !rom_alpha : 1'b1;
  end

  platform_sprite_rom u_rom (
    .row   (win_row),
    .col   (win_col),
    .rgb   (rom_rgb),
    .alpha (rom_alpha)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        y_q[i] <= home_y(i);
        x_q[i] <= home_x(i);
      end
      active_q <= N'(START_MASK);
      moving_q <= '0;
      dir_q    <= '0;
      cnt_q    <= '0;
      color_q  <= '1;
      transp_q <= 1'b1;
    end else begin
      y_q      <= y_d;
      x_q      <= x_d;
      active_q <= active_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      color_q  <= color_d;
      transp_q <= transp_d;
    end
  end

  assign bus.plat_y         = y_q;
  assign bus.plat_x         = x_q;
  assign bus.plat_active    = active_q;
  assign bus.plat_moving    = moving_q;
  assign bus.scroll_busy    = (cnt_q != '0);
  assign bus.color          = color_q;
  assign bus.is_transparent = transp_q;
endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field: reset, pixel lookup, scroll bursts, bank recycling,
// moving-platform clamping and an asynchronous reset in the middle of a burst.
module tb_platform_field;
  import platform_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  platform_field_if #(.N(90), .RND_W(15)) bus ();

  platform_field dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      @(posedge clk);
      #1;
      bus.scroll_req = 1'b0;
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic beam(input int bx, input int by);
    bus.beam_x = 11'(bx);
    bus.beam_y = 10'(by);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.frame_tick = 1'b0;
    bus.scroll_req = 1'b0;
    bus.rnd        = '0;
    bus.beam_x     = '0;
    bus.beam_y     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_y0",     bus.plat_y[0], -162);
    check("rst_y89",    bus.plat_y[89], 708);
    check("rst_x74",    $unsigned(bus.plat_x[74]), 570);
    check("rst_busy",   bus.scroll_busy, 0);
    check("rst_active", bus.plat_active, START_MASK);
    check("rst_moving", bus.plat_moving, 0);
    check("rst_color",  bus.color, 12'hFFF);
    check("rst_transp", bus.is_transparent, 1);

    beam(347, 23);
    check("pix_grass_c",  bus.color, 12'h2C3);
    check("pix_grass_t",  bus.is_transparent, 0);
    beam(342, 18);
    check("pix_corner_c", bus.color, 12'hFFF);
    check("pix_corner_t", bus.is_transparent, 1);
    beam(347, 40);
    check("pix_soil_c",   bus.color, 12'h852);
    check("pix_soil_t",   bus.is_transparent, 0);
    beam(442, 23);
    check("pix_redge_t",  bus.is_transparent, 1);
    beam(347, 50);
    check("pix_inact_c",  bus.color, 12'hFFF);
    check("pix_inact_t",  bus.is_transparent, 1);
    beam(458, 50);
    check("pix_r7c1_c",   bus.color, 12'h2C3);
    beam(0, 0);
    check("pix_off_c",    bus.color, 12'hFFF);
    check("pix_off_t",    bus.is_transparent, 1);

    bus.scroll_req = 1'b1;
    @(posedge clk);
    #1;
    check("gate_y0",   bus.plat_y[0], -162);
    check("gate_busy", bus.scroll_busy, 0);

    frames(1);
    check("b1_y0_f1",   bus.plat_y[0], -150);
    check("b1_busy_f1", bus.scroll_busy, 1);
    bus.scroll_req = 1'b1;
    frames(1);
    check("b1_y0_f2",   bus.plat_y[0], -138);
    frames(18);
    check("b1_y0",      bus.plat_y[0], 30);
    check("b1_busy",    bus.scroll_busy, 0);
    check("b1_y75",     bus.plat_y[75], -120);
    check("b1_y89",     bus.plat_y[89], 0);
    check("b1_y74",     bus.plat_y[74], 750);
    check("b1_act_b5",  bus.plat_active[89:75], 15'h4000);
    check("b1_mov_b5",  bus.plat_moving[89:75], 0);

    bus.rnd        = 30'h2000_7FFF;
    bus.scroll_req = 1'b1;
    frames(16);
    check("b2_y0",      bus.plat_y[0], 222);
    check("b2_y60",     bus.plat_y[60], -78);
    check("b2_y74",     bus.plat_y[74], 42);
    check("b2_act_b4",  bus.plat_active[74:60], 15'h7FFF);
    check("b2_mov_b4",  bus.plat_moving[74:60], 15'h4000);
    check("b2_x74",     $unsigned(bus.plat_x[74]), 576);
    check("b2_busy",    bus.scroll_busy, 0);

    bus.rnd = '0;
    frames(252);
    check("mv_x74_hi",  $unsigned(bus.plat_x[74]), 1080);
    frames(1);
    check("mv_clamp",   $unsigned(bus.plat_x[74]), 1080);
    frames(1);
    check("mv_back",    $unsigned(bus.plat_x[74]), 1078);
    check("mv_static",  $unsigned(bus.plat_x[73]), 456);
    check("mv_y60",     bus.plat_y[60], -78);

    bus.scroll_req = 1'b1;
    frames(7);
    check("mid_busy",   bus.scroll_busy, 1);
    beam(347, 23);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ar_y0",      bus.plat_y[0], -162);
    check("ar_y89",     bus.plat_y[89], 708);
    check("ar_busy",    bus.scroll_busy, 0);
    check("ar_active",  bus.plat_active, START_MASK);
    check("ar_moving",  bus.plat_moving, 0);
    check("ar_x74",     $unsigned(bus.plat_x[74]), 570);
    check("ar_color",   bus.color, 12'hFFF);
    rst = 1'b0;
    beam(347, 23);
    check("ar_pix_c",   bus.color, 12'h2C3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
